// File: rtl/perceptron_trainer.sv
// perceptron_trainer: stores up to DEPTH labelled samples and replays them epoch by
// epoch to an external perceptron until an error-free epoch or the epoch limit. Rev 1.0
`default_nettype none

module perceptron_trainer #(
  parameter int DEPTH      = 8,
  parameter int RESULT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [7:0]                 load_data,
  input  logic [7:0]                 thr_in,
  input  logic [7:0]                 max_epochs,
  input  logic                       start,
  output logic [6:0]                 p_in,
  output logic [7:0]                 p_threshold,
  output logic                       p_exp_res,
  input  logic [1:0]                 p_result,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [7:0]                 epoch_cnt,
  output logic [$clog2(DEPTH):0]     err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (RESULT_LAT < 1) ? 1 : $clog2(RESULT_LAT + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, EPOCH_END, FIN} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [CW-1:0]   count;
  logic [CW-1:0]   acc;
  logic [AW-1:0]   k;
  logic [HW-1:0]   hold;
  logic [7:0]      limit;
  logic [7:0]      sample;
  logic            load_fire;
  logic            last_hold;
  logic            last_k;
  logic            mismatch;
  logic [1:0]      exp_code;

  assign load_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load_fire  = load_valid && load_ready;
  assign sample     = mem[k];
  assign last_hold  = (hold == HW'(RESULT_LAT));
  assign last_k     = ({1'b0, k} == count - 1'b1);
  assign exp_code   = sample[7] ? 2'b01 : 2'b11;
  // Any code other than the expected one, including the undefined 2'b00/2'b10, is an error.
  assign mismatch   = (p_result != exp_code);
  assign p_in       = (state == DRIVE) ? sample[6:0] : 7'd0;
  assign p_exp_res  = (state == DRIVE) ? sample[7] : 1'b0;
  assign done       = (state == FIN);

  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[count[AW-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          // A load landing in the same cycle as start still counts as a stored sample.
          state_n = (count == '0 && !load_fire) ? FIN : DRIVE;
        end
      end
      DRIVE: begin
        if (last_hold && last_k) begin
          state_n = EPOCH_END;
        end
      end
      EPOCH_END: begin
        if (acc == '0 || (epoch_cnt + 8'd1) == limit) begin
          state_n = FIN;
        end else begin
          state_n = DRIVE;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      k           <= '0;
      hold        <= '0;
      limit       <= 8'd0;
      p_threshold <= 8'd0;
      busy        <= 1'b0;
      converged   <= 1'b0;
      epoch_cnt   <= 8'd0;
      err_cnt     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (load_fire) begin
            count <= count + 1'b1;
          end
          if (start) begin
            p_threshold <= thr_in;
            limit       <= (max_epochs == 8'd0) ? 8'd1 : max_epochs;
            epoch_cnt   <= 8'd0;
            err_cnt     <= '0;
            converged   <= 1'b0;
            acc         <= '0;
            busy        <= 1'b1;
            k           <= '0;
            hold        <= '0;
          end
        end
        DRIVE: begin
          if (last_hold) begin
            hold <= '0;
            if (mismatch) begin
              acc <= acc + 1'b1;
            end
            if (!last_k) begin
              k <= k + 1'b1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        EPOCH_END: begin
          epoch_cnt <= epoch_cnt + 8'd1;
          err_cnt   <= acc;
          acc       <= '0;
          k         <= '0;
          if (acc == '0) begin
            converged <= 1'b1;
          end
        end
        FIN: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of training samples stored (power of 2, >=2).
REQ-002 SHALL have parameter RESULT_LAT, default 2, cycles from a stable p_in to a valid p_result.
REQ-003 SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  sample-load request.
REQ-006 SHALL have port load_ready  output  1  sample-load accept.
REQ-007 SHALL have port load_data  input  8  sample: [7]=exp_res, [6:0]=input vector.
REQ-008 SHALL have port thr_in  input  8  activation threshold, captured on start.
REQ-009 SHALL have port max_epochs  input  8  epoch limit, captured on start.
REQ-010 SHALL have port start  input  1  one-cycle run request.
REQ-011 SHALL have port p_in  output  7  input vector driven to the perceptron.
REQ-012 SHALL have port p_threshold  output  8  threshold driven to the perceptron.
REQ-013 SHALL have port p_exp_res  output  1  expected result driven to the perceptron.
REQ-014 SHALL have port p_result  input  2  perceptron result: 2'b01 = +1, 2'b11 = -1.
REQ-015 SHALL have port busy  output  1  run in progress.
REQ-016 SHALL have port done  output  1  one-cycle run-complete pulse.
REQ-017 SHALL have port converged  output  1  last run ended with an error-free epoch.
REQ-018 SHALL have port epoch_cnt  output  8  epochs completed in the current or last run.
REQ-019 SHALL have port err_cnt  output  $clog2(DEPTH)+1  mismatches in the last completed epoch.

Function
REQ-020 SHALL implement FSM states IDLE, DRIVE, EPOCH_END, FIN.
REQ-021 In IDLE, load_ready SHALL be 1 when stored count < DEPTH; otherwise 0, and it SHALL be 0 in every other state.
REQ-022 A load_valid&&load_ready cycle SHALL write load_data at index count and increment count; loads beyond DEPTH are impossible because load_ready=0.
REQ-023 start in IDLE SHALL capture thr_in into p_threshold and max(max_epochs,1) as the limit, clear epoch_cnt, err_cnt, converged and the error accumulator, set busy=1, set sample index k=0 and enter DRIVE; start outside IDLE SHALL be ignored.
REQ-024 start with count==0 SHALL go directly to FIN, ending with converged=0 and epoch_cnt=0.
REQ-025 Simultaneous load handshake and start in IDLE: the load SHALL complete, and the run SHALL include that sample.
REQ-026 In DRIVE, p_in and p_exp_res SHALL hold sample k for exactly RESULT_LAT+1 cycles, counted by a hold counter running 0..RESULT_LAT.
REQ-027 On the cycle where hold==RESULT_LAT, p_result SHALL be compared with the expected value (exp_res 1 -> 2'b01, 0 -> 2'b11); a mismatch, including 2'b00 or 2'b10, SHALL increment the accumulator.
REQ-028 After the compare, if k < count-1, k SHALL increment and DRIVE SHALL restart; otherwise the FSM SHALL go to EPOCH_END.
REQ-029 EPOCH_END (1 cycle) SHALL increment epoch_cnt, copy the accumulator into err_cnt and clear the accumulator.
REQ-030 From EPOCH_END, zero errors SHALL set converged=1 and go to FIN; else epoch_cnt==limit SHALL go to FIN with converged=0; else k=0 and the FSM SHALL return to DRIVE.
REQ-031 FIN (1 cycle) SHALL assert done=1, clear busy and return to IDLE; the stored samples and count SHALL be retained for the next start.
REQ-032 epoch_cnt SHALL NOT wrap; the limit is at most 255, so termination is guaranteed.
REQ-033 The per-epoch cycle count SHALL be exactly count*(RESULT_LAT+1)+1.

Reset
REQ-034 reset=1 at a clock edge SHALL, in any state including mid-run, force IDLE, count=0, k=0, and set p_in=0, p_threshold=0, p_exp_res=0, busy=0, done=0, converged=0, epoch_cnt=0, err_cnt=0; load_ready SHALL be 1 on the following cycle.

Verification
REQ-035 Load 4 samples, start with the responder echoing the expected value after 2 cycles -> epoch_cnt=1, err_cnt=0, converged=1, done exactly 13 cycles after DRIVE entry.
REQ-036 Responder always returns 2'b11 with 2 of 4 samples exp_res=1 and max_epochs=3 -> done after 3 epochs, err_cnt=2, converged=0.
REQ-037 Load DEPTH samples with load_valid held high -> load_ready drops after the 8th accept, and a 9th word is not stored.
REQ-038 start with count==0 -> done pulse within 2 cycles, converged=0, epoch_cnt=0; max_epochs=0 with a wrong responder -> exactly 1 epoch.
REQ-039 Assert reset mid-DRIVE -> all outputs take reset values next cycle, and a following start with no new loads takes the empty path.
REQ-040 Responder returns 2'b00 -> every sample counts as an error; start pulsed while busy -> ignored, with no epoch_cnt change.
